// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture
//   Turns the Game Boy LCD interface (hs/vs/cpl + 2-bit pixel) into linear
//   frame-buffer writes for a WIDTH x HEIGHT BRAM. Tracks x/y, drops pixels
//   beyond WIDTH, rejects malformed lines/frames and pulses frame_done when a
//   full frame has been written.
//
// Optional feature macro: GB_CAPTURE_ERR_CNT_EN
//   defined   -> err_cnt counts short/long lines and short frames (saturating)
//   undefined -> err_cnt tied to 0, counting logic removed
//
// Ports
//   clk, reset            Game Boy clock, synchronous active-high reset
//   lcd_on                LCD enable; low parks the capture until the next vs
//   lcd_hs/lcd_vs/lcd_cpl line end / frame start / pixel strobe (rising edges)
//   lcd_pixel             pixel data sampled on cpl rise
//   fb_we/fb_addr/fb_pixel frame-buffer write port (addr = y*WIDTH + x)
//   frame_done            1-cycle pulse after the last line of a frame
//   frame_cnt             completed frames, wraps
//   err_cnt               malformed line/frame count
module gb_lcd_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_on,
  input  logic              lcd_hs,
  input  logic              lcd_vs,
  input  logic              lcd_cpl,
  input  logic [1:0]        lcd_pixel,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [1:0]        fb_pixel,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic [15:0]       err_cnt
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]     X_END   = XW'(WIDTH);
  localparam logic [YW-1:0]     Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LB_STEP = ADDR_W'(WIDTH);

  typedef enum logic {S_WAIT_VS, S_ACTIVE} state_t;

  state_t            state;
  logic              hs_q, vs_q, cpl_q;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] line_base;
  logic              line_long;

  logic              hs_rise, vs_rise, cpl_rise;
  logic              take_px;
  logic [XW-1:0]     x_px;
  logic              long_px;
  logic              line_end;

  assign hs_rise  = lcd_hs  & ~hs_q;
  assign vs_rise  = lcd_vs  & ~vs_q;
  assign cpl_rise = lcd_cpl & ~cpl_q;

  // A pixel arriving with hs belongs to the line being closed, so the line-end
  // decision looks at x/long after this cycle's pixel has been accounted for.
  assign take_px  = cpl_rise && (x < X_END);
  assign x_px     = x + XW'(take_px);
  assign long_px  = line_long | (cpl_rise && (x == X_END));
  assign line_end = hs_rise && (x_px != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_WAIT_VS;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      cpl_q      <= 1'b0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      line_long  <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_pixel   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      hs_q       <= lcd_hs;
      vs_q       <= lcd_vs;
      cpl_q      <= lcd_cpl;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (!lcd_on) begin
        x         <= '0;
        y         <= '0;
        line_base <= '0;
        line_long <= 1'b0;
        state     <= S_WAIT_VS;
      end else begin
        case (state)
          S_WAIT_VS: begin
            if (vs_rise) begin
              x         <= '0;
              y         <= '0;
              line_base <= '0;
              line_long <= 1'b0;
              state     <= S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            if (vs_rise) begin
              // restart; any concurrent hs/cpl is discarded
              x         <= '0;
              y         <= '0;
              line_base <= '0;
              line_long <= 1'b0;
            end else begin
              if (take_px) begin
                fb_we    <= 1'b1;
                fb_addr  <= line_base + ADDR_W'(x);
                fb_pixel <= lcd_pixel;
              end
              x         <= x_px;
              line_long <= long_px;
              if (line_end) begin
                x         <= '0;
                line_long <= 1'b0;
                y         <= y + 1'b1;
                line_base <= line_base + LB_STEP;
                if (y == Y_LAST) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 1'b1;
                  state      <= S_WAIT_VS;
                end
              end
            end
          end
          default: state <= S_WAIT_VS;
        endcase
      end
    end
  end

`ifdef GB_CAPTURE_ERR_CNT_EN
  logic line_bad;
  logic err_inc;

  assign line_bad = (x_px < X_END) || long_px;
  // vs while active always means y < HEIGHT: reaching HEIGHT leaves S_ACTIVE.
  assign err_inc  = lcd_on && (state == S_ACTIVE) &&
                    (vs_rise || (line_end && line_bad));

  always_ff @(posedge clk) begin
    if (reset)
      err_cnt <= '0;
    else if (err_inc && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 1'b1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Randomized/directed bench for gb_lcd_capture. Stimulus is issued as LCD
// events (pixel, line end, frame start, display off); a reference model keeps
// the expected frame position and derives every write address as y*WIDTH+x.
module tb_gb_lcd_capture;
  localparam int W  = 160;
  localparam int H  = 144;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          lcd_on, lcd_hs, lcd_vs, lcd_cpl;
  logic [1:0]    lcd_pixel;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [1:0]    fb_pixel;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic [15:0]   err_cnt;

  gb_lcd_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .lcd_on(lcd_on), .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs), .lcd_cpl(lcd_cpl), .lcd_pixel(lcd_pixel),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_pixel(fb_pixel),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_active;
  int m_x, m_y, m_err, m_frames;
  bit m_long;
  int last_addr, last_pix;

  int act_writes = 0;
  always @(posedge clk) if (fb_we === 1'b1) act_writes <= act_writes + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef GB_CAPTURE_ERR_CNT_EN
    return (m_err > 65535) ? 65535 : m_err;
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] rp();
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic check_outs(input bit we, input bit done);
    chk("fb_we", fb_we, we);
    chk("frame_done", frame_done, done);
    chk("fb_addr", fb_addr, last_addr);
    chk("fb_pixel", fb_pixel, last_pix);
    chk("frame_cnt", frame_cnt, m_frames % 256);
    chk("err_cnt", err_cnt, exp_err());
  endtask

  // One LCD event: strobes high for one cycle, then low for one cycle.
  task automatic step(input bit cpl, input bit hs, input bit vs, input bit on,
                      input logic [1:0] pix);
    bit we = 0, done = 0;
    lcd_cpl = cpl; lcd_hs = hs; lcd_vs = vs; lcd_on = on; lcd_pixel = pix;
    if (!on) begin
      m_active = 0; m_x = 0; m_y = 0; m_long = 0;
    end else if (!m_active) begin
      if (vs) begin m_active = 1; m_x = 0; m_y = 0; m_long = 0; end
    end else if (vs) begin
      m_err++; m_x = 0; m_y = 0; m_long = 0;
    end else begin
      if (cpl) begin
        if (m_x < W) begin
          we = 1; last_addr = m_y * W + m_x; last_pix = pix; m_x++;
        end else m_long = 1;
      end
      if (hs && m_x > 0) begin
        if (m_x < W || m_long) m_err++;
        m_x = 0; m_long = 0; m_y++;
        if (m_y == H) begin done = 1; m_frames++; m_active = 0; end
      end
    end
    @(posedge clk); #1;
    check_outs(we, done);
    lcd_cpl = 0; lcd_hs = 0; lcd_vs = 0; lcd_pixel = rp();
    @(posedge clk); #1;
    check_outs(0, 0);
  endtask

  task automatic px();        step(1, 0, 0, 1, rp()); endtask
  task automatic hsync();     step(0, 1, 0, 1, 2'd0); endtask
  task automatic vsync();     step(0, 0, 1, 1, 2'd0); endtask

  // n pixels then hs; comb folds hs into the last pixel's cycle
  task automatic line(input int n, input bit comb);
    for (int i = 0; i < n; i++) begin
      if (comb && i == n - 1) step(1, 1, 0, 1, rp());
      else px();
    end
    if (!comb || n == 0) hsync();
  endtask

  task automatic do_reset();
    reset = 1; lcd_on = 1; lcd_hs = 0; lcd_vs = 0; lcd_cpl = 0; lcd_pixel = 0;
    @(posedge clk); #1;
    m_active = 0; m_x = 0; m_y = 0; m_long = 0; m_err = 0; m_frames = 0;
    last_addr = 0; last_pix = 0;
    check_outs(0, 0);
    reset = 0;
    @(posedge clk); #1;
    check_outs(0, 0);
  endtask

  initial begin
    int w0;
    reset = 1; lcd_on = 0; lcd_hs = 0; lcd_vs = 0; lcd_cpl = 0; lcd_pixel = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    px(); px();                         // ignored before first vs

    // full frame, some lines closing with cpl+hs on the last pixel
    w0 = act_writes;
    vsync();
    for (int l = 0; l < H; l++) line(W, (l % 7) == 3);
    chk("t1_writes", act_writes - w0, 23040);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_last_addr", fb_addr, 23039);

    // long line
    vsync();
    line(162, 0);
    px();
    chk("t2_next_addr", fb_addr, 160);

    // short line (preceded by a short-frame vs)
    vsync();
    line(100, 0);
    px();
    chk("t3_next_addr", fb_addr, 160);

    // short frame after 50 full lines
    vsync();
    for (int l = 0; l < 50; l++) line(W, 0);
    vsync();
    px();
    chk("t4_next_addr", fb_addr, 0);

    // display off mid-line 10
    hsync();
    for (int l = 1; l < 10; l++) line(W, 0);
    repeat (5) px();
    step(1, 0, 0, 0, rp());
    repeat (3) step(1, 0, 0, 0, rp());
    repeat (3) px();                    // on again, waiting for vs
    vsync();
    px();
    chk("t5_next_addr", fb_addr, 0);

    // reset mid-frame
    repeat (7) px();
    do_reset();
    px(); hsync(); px();
    vsync();
    px();

    // random lines and disturbances
    for (int l = 0; l < 40; l++) begin
      int r, n;
      r = $urandom_range(0, 99);
      if (r < 8)       vsync();
      else if (r < 12) step(1, 0, 1, 1, rp());
      else if (r < 15) step(0, 1, 1, 1, 2'd0);
      else if (r < 19) begin step(0, 0, 0, 0, 2'd0); vsync(); end
      n = ($urandom_range(0, 1) == 1) ? W : int'($urandom_range(0, 170));
      line(n, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
